// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified memory arbiter:
//                FSM states, requester identities, access sizes and the
//                read/write encoding seen by the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    // The requester that did not own the port last time.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_IF) ? OWNER_D : OWNER_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the fetch, data and memory-side signals around
//                the memory arbiter. The slave view belongs to the arbiter,
//                the master view to the requesters/memory around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    // data side
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_read_write;
    logic [1:0]        d_access_size;
    logic              d_unsigned;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    // memory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_read_write;
    logic [1:0]        mem_access_size;
    logic              mem_unsigned;
    logic              mem_enable;
    logic [DATA_W-1:0] mem_data_out;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  d_req, d_addr, d_wdata, d_read_write, d_access_size, d_unsigned,
        output d_gnt, d_valid, d_rdata,
        output mem_address, mem_data_in, mem_read_write, mem_access_size,
        output mem_unsigned, mem_enable,
        input  mem_data_out,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output d_req, d_addr, d_wdata, d_read_write, d_access_size, d_unsigned,
        input  d_gnt, d_valid, d_rdata,
        input  mem_address, mem_data_in, mem_read_write, mem_access_size,
        input  mem_unsigned, mem_enable,
        output mem_data_out,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-requester round-robin pick. req[0] is the
//                fetch requester, req[1] the data requester. On a tie the
//                requester that did not win last time is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       grant_valid,
    output owner_t     winner
);

    // Single requester wins outright; a tie alternates away from last_owner.
    always_comb begin
        grant_valid = |req;
        winner      = OWNER_IF;
        if (req == 2'b11) begin
            winner = other_owner(last_owner);
        end else if (req[1]) begin
            winner = OWNER_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory port between instruction fetch and data
//                load/store. Round-robin pick in IDLE, registered grant,
//                fixed-latency ACCESS phase, one-cycle valid on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int               C_CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(MEM_LATENCY - 1);

    generate
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $error("mem_arbiter: MEM_LATENCY must be at least 1");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CNT_W-1:0]  w_cnt_nxt;

    owner_t              r_owner;
    owner_t              r_last_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rw;
    logic [1:0]          r_size;
    logic                r_uns;

    logic                r_if_gnt;
    logic                r_d_gnt;
    logic                r_if_valid;
    logic                r_d_valid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_grant_valid;
    owner_t              w_winner;
    logic                w_latch;
    logic                w_if_gnt_nxt;
    logic                w_d_gnt_nxt;
    logic                w_if_valid_nxt;
    logic                w_d_valid_nxt;
    logic                w_cap_if;
    logic                w_cap_d;

    rr_arb2 u_rr_arb2 (
        .req         ({bus.d_req, bus.if_req}),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .winner      (w_winner)
    );

    // FSM state and latency counter; reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, grant/valid pulses and capture enables.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_latch        = 1'b0;
        w_if_gnt_nxt   = 1'b0;
        w_d_gnt_nxt    = 1'b0;
        w_if_valid_nxt = 1'b0;
        w_d_valid_nxt  = 1'b0;
        w_cap_if       = 1'b0;
        w_cap_d        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = C_CNT_LOAD;
                    if (w_winner == OWNER_D) begin
                        w_d_gnt_nxt = 1'b1;
                    end else begin
                        w_if_gnt_nxt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    if (r_owner == OWNER_D) begin
                        w_d_valid_nxt = 1'b1;
                        w_cap_d       = (r_rw == MEM_READ);
                    end else begin
                        w_if_valid_nxt = 1'b1;
                        w_cap_if       = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, handshake pulses and read-data capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner      <= OWNER_IF;
            r_last_owner <= OWNER_IF;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_if_gnt     <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_if_gnt   <= w_if_gnt_nxt;
            r_d_gnt    <= w_d_gnt_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_d_valid  <= w_d_valid_nxt;
            if (w_latch) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                if (w_winner == OWNER_D) begin
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                    r_rw    <= bus.d_read_write;
                    r_size  <= bus.d_access_size;
                    r_uns   <= bus.d_unsigned;
                end else begin
                    // fetches are always unsigned-agnostic word reads
                    r_addr  <= bus.if_addr;
                    r_wdata <= '0;
                    r_rw    <= MEM_READ;
                    r_size  <= SIZE_WORD;
                    r_uns   <= 1'b0;
                end
            end
            if (w_cap_if) begin
                r_if_rdata <= bus.mem_data_out;
            end
            if (w_cap_d) begin
                r_d_rdata <= bus.mem_data_out;
            end
        end
    end

    // Memory fields come only from the latch, never straight from a request.
    assign bus.mem_address     = r_addr;
    assign bus.mem_data_in     = r_wdata;
    assign bus.mem_read_write  = r_rw;
    assign bus.mem_access_size = r_size;
    assign bus.mem_unsigned    = r_uns;
    assign bus.mem_enable      = (r_state == ACCESS);
    assign bus.busy            = (r_state == ACCESS);

    assign bus.if_gnt   = r_if_gnt;
    assign bus.d_gnt    = r_d_gnt;
    assign bus.if_valid = r_if_valid;
    assign bus.d_valid  = r_d_valid;
    assign bus.if_rdata = r_if_rdata;
    assign bus.d_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Bench for mem_arbiter. Two instances (latency 1 and 3) see
//                the same stimulus; each is compared every cycle against a
//                transaction-level reference model, plus directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rw;
    logic [1:0]  d_size;
    logic        d_uns;
    logic [31:0] mdo;

    mem_arbiter_if b1 ();
    mem_arbiter_if b3 ();

    assign b1.if_req = if_req;        assign b3.if_req = if_req;
    assign b1.if_addr = if_addr;      assign b3.if_addr = if_addr;
    assign b1.d_req = d_req;          assign b3.d_req = d_req;
    assign b1.d_addr = d_addr;        assign b3.d_addr = d_addr;
    assign b1.d_wdata = d_wdata;      assign b3.d_wdata = d_wdata;
    assign b1.d_read_write = d_rw;    assign b3.d_read_write = d_rw;
    assign b1.d_access_size = d_size; assign b3.d_access_size = d_size;
    assign b1.d_unsigned = d_uns;     assign b3.d_unsigned = d_uns;
    assign b1.mem_data_out = mdo;     assign b3.mem_data_out = mdo;

    mem_arbiter #(.MEM_LATENCY(1)) u_l1 (.clock(clock), .reset(reset), .bus(b1));
    mem_arbiter #(.MEM_LATENCY(3)) u_l3 (.clock(clock), .reset(reset), .bus(b3));

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model, index 0 -> latency 1, index 1 -> latency 3
    int          lat [2] = '{1, 3};
    bit          m_busy [2];
    int          m_left [2];
    bit          m_own  [2];   // 0 fetch, 1 data
    bit          m_last [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_din  [2];
    logic        m_rw   [2];
    logic [1:0]  m_sz   [2];
    logic        m_uns  [2];
    logic        m_ig [2], m_dg [2], m_iv [2], m_dv [2];
    logic [31:0] m_ir [2], m_dr [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_busy[k] = 0; m_left[k] = 0; m_own[k] = 0; m_last[k] = 0;
        m_addr[k] = '0; m_din[k] = '0; m_rw[k] = 0; m_sz[k] = '0; m_uns[k] = 0;
        m_ig[k] = 0; m_dg[k] = 0; m_iv[k] = 0; m_dv[k] = 0;
        m_ir[k] = '0; m_dr[k] = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step(input int k);
        bit pick_d;
        m_ig[k] = 0; m_dg[k] = 0; m_iv[k] = 0; m_dv[k] = 0;
        if (!m_busy[k]) begin
            if (if_req || d_req) begin
                pick_d = d_req && (!if_req || (m_last[k] == 0));
                if (pick_d) begin
                    m_addr[k] = d_addr; m_din[k] = d_wdata; m_rw[k] = d_rw;
                    m_sz[k] = d_size; m_uns[k] = d_uns; m_dg[k] = 1;
                end else begin
                    m_addr[k] = if_addr; m_din[k] = '0; m_rw[k] = 1;
                    m_sz[k] = 2'b10; m_uns[k] = 0; m_ig[k] = 1;
                end
                m_own[k] = pick_d; m_last[k] = pick_d;
                m_busy[k] = 1; m_left[k] = lat[k];
            end
        end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_busy[k] = 0;
                if (m_own[k]) begin
                    m_dv[k] = 1;
                    if (m_rw[k]) m_dr[k] = mdo;
                end else begin
                    m_iv[k] = 1;
                    m_ir[k] = mdo;
                end
            end
        end
    endtask

    task automatic cmp_dut(input int k, input logic ig, dg, iv, dv,
                           input logic [31:0] ir, dr, ad, di,
                           input logic rw, input logic [1:0] sz,
                           input logic un, en, bz);
        string p;
        p = (k == 0) ? "L1_" : "L3_";
        chk({p, "if_gnt"}, ig, m_ig[k]);
        chk({p, "d_gnt"}, dg, m_dg[k]);
        chk({p, "if_valid"}, iv, m_iv[k]);
        chk({p, "d_valid"}, dv, m_dv[k]);
        chk({p, "if_rdata"}, ir, m_ir[k]);
        chk({p, "d_rdata"}, dr, m_dr[k]);
        chk({p, "mem_address"}, ad, m_addr[k]);
        chk({p, "mem_data_in"}, di, m_din[k]);
        chk({p, "mem_read_write"}, rw, m_rw[k]);
        chk({p, "mem_access_size"}, sz, m_sz[k]);
        chk({p, "mem_unsigned"}, un, m_uns[k]);
        chk({p, "mem_enable"}, en, m_busy[k]);
        chk({p, "busy"}, bz, m_busy[k]);
    endtask

    task automatic compare_all();
        cmp_dut(0, b1.if_gnt, b1.d_gnt, b1.if_valid, b1.d_valid, b1.if_rdata, b1.d_rdata,
                b1.mem_address, b1.mem_data_in, b1.mem_read_write, b1.mem_access_size,
                b1.mem_unsigned, b1.mem_enable, b1.busy);
        cmp_dut(1, b3.if_gnt, b3.d_gnt, b3.if_valid, b3.d_valid, b3.if_rdata, b3.d_rdata,
                b3.mem_address, b3.mem_data_in, b3.mem_read_write, b3.mem_access_size,
                b3.mem_unsigned, b3.mem_enable, b3.busy);
    endtask

    // Advance one cycle; returns 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (!reset) model_reset(k);
            else        model_step(k);
        end
        #1;
        compare_all();
    endtask

    initial begin
        int          n_g;
        int          order [4];
        int          got;
        int          nb;
        int          vi;
        int          ng;
        int          nv;
        int          last1;
        int          last3;
        int          cnt1;
        int          cnt3;

        model_reset(0);
        model_reset(1);
        reset = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_addr = '0; d_wdata = '0;
        d_rw = 0; d_size = 2'b00; d_uns = 0; mdo = '0;
        step();
        step();
        reset = 1'b1;

        // fetch only
        if_req = 1; if_addr = 32'h100; mdo = 32'h00500093;
        step();
        chk("ifonly_gnt", b1.if_gnt, 1);
        chk("ifonly_en", b1.mem_enable, 1);
        chk("ifonly_addr", b1.mem_address, 32'h100);
        chk("ifonly_rw", b1.mem_read_write, 1);
        chk("ifonly_size", b1.mem_access_size, 2'b10);
        if_req = 0;
        step();
        chk("ifonly_valid", b1.if_valid, 1);
        chk("ifonly_rdata", b1.if_rdata, 32'h00500093);
        repeat (4) step();

        // contention: data store vs fetch, both held
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_rw = 0; d_size = 2'b10; d_uns = 0;
        n_g = 0;
        for (int i = 0; i < 40 && n_g < 4; i++) begin
            step();
            if (b1.d_gnt) begin
                order[n_g] = 1; n_g++;
                chk("store_rw", b1.mem_read_write, 0);
                chk("store_wdata", b1.mem_data_in, 32'hDEADBEEF);
            end else if (b1.if_gnt) begin
                order[n_g] = 0; n_g++;
            end
        end
        chk("rr_grant_count", n_g, 4);
        chk("rr_order0_d", order[0], 1);
        chk("rr_order1_if", order[1], 0);
        chk("rr_order2_d", order[2], 1);
        chk("rr_order3_if", order[3], 0);
        if_req = 0; d_req = 0;
        repeat (6) step();
        chk("store_d_rdata", b1.d_rdata, 32'h0);

        // byte load, unsigned, observed on the latency-3 instance
        d_req = 1; d_rw = 1; d_size = 2'b00; d_uns = 1; d_addr = 32'h3001; mdo = 32'h000000A5;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step();
            got = b3.d_gnt ? 1 : 0;
        end
        chk("load_gnt", got, 1);
        chk("load_busy_at_gnt", b3.busy, 1);
        d_req = 0;
        nb = 1; vi = -1; ng = 0;
        for (int i = 0; i < 6; i++) begin
            if_req = (i == 0);
            step();
            if (b3.busy) begin
                nb++;
                chk("load_size", b3.mem_access_size, 2'b00);
                chk("load_unsigned", b3.mem_unsigned, 1);
            end
            if (b3.d_valid && vi < 0) vi = i;
            if (b3.d_gnt || b3.if_gnt) ng++;
        end
        chk("load_busy_cycles", nb, 3);
        chk("load_valid_offset", vi, 2);
        chk("load_no_extra_gnt", ng, 0);
        chk("load_rdata", b3.d_rdata, 32'h000000A5);
        repeat (3) step();

        // reset while the latency-3 access has one cycle left
        d_req = 1; d_addr = 32'h4000; mdo = 32'h12345678;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step();
            got = b3.d_gnt ? 1 : 0;
        end
        chk("rst_setup_gnt", got, 1);
        d_req = 0;
        step();
        #2 reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        step();
        reset = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (b3.d_valid || b3.if_valid || b1.d_valid || b1.if_valid) nv++;
        end
        chk("rst_no_valid", nv, 0);
        if_req = 1; d_req = 1; d_rw = 1;
        step();
        chk("rst_tie_d", b3.d_gnt, 1);
        chk("rst_tie_not_if", b3.if_gnt, 0);
        if_req = 0; d_req = 0;
        repeat (6) step();

        // back-to-back fetches with request held
        if_req = 1;
        last1 = -1; last3 = -1; cnt1 = 0; cnt3 = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (b1.if_gnt) begin
                if (last1 >= 0) chk("b2b_interval_L1", i - last1, 2);
                last1 = i; cnt1++;
            end
            if (b3.if_gnt) begin
                if (last3 >= 0) chk("b2b_interval_L3", i - last3, 4);
                last3 = i; cnt3++;
            end
        end
        chk("b2b_count_L1", cnt1, 15);
        chk("b2b_count_L3", cnt3, 8);
        if_req = 0;
        repeat (6) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if_req  = ($urandom_range(0, 3) != 0);
            d_req   = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_rw    = $urandom_range(0, 1) == 1;
            d_size  = 2'($urandom_range(0, 2));
            d_uns   = $urandom_range(0, 1) == 1;
            mdo     = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Enables the multi-cycle/pipelined core to run from a single `mem` instance instead of separate imem and dmem.
- Sits between `fetch`/`dmem`-side control and the memory.
- Round-robin arbitration, registered grant, fixed-latency memory access with a completion pulse.

Parameters:
- MEM_LATENCY, 1, cycles from mem_enable assertion to valid mem_data_out; must be >= 1 (elaboration error otherwise).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address (word read)
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with all d_* fields stable until d_gnt
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_read_write  in  1  1 = read (load), 0 = write (store)
- d_access_size  in  2  00 byte, 01 half, 10 word
- d_unsigned  in  1  unsigned load extension
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: load data valid / store complete
- d_rdata  out  DATA_W  load data
- mem_address  out  ADDR_W  to memory
- mem_data_in  out  DATA_W  to memory
- mem_read_write  out  1  to memory
- mem_access_size  out  2  to memory
- mem_unsigned  out  1  to memory
- mem_enable  out  1  to memory
- mem_data_out  in  DATA_W  from memory
- busy  out  1  high while an access is in flight

Behaviour:
- States: IDLE, ACCESS.
- Reset (async, reset==0):
  - State IDLE; counter 0.
  - All outputs 0, including rdata registers and the latched request fields.
  - last_owner = IF, so the first tie goes to D.
  - Reset mid-ACCESS aborts the access: no valid pulse, no gnt.
- IDLE, no req: mem_enable=0, busy=0; mem_* fields hold last latched values.
- IDLE, one req: that requester wins.
- IDLE, both req: winner is the one that is not last_owner (round-robin).
- On acceptance at edge of cycle T:
  - Latch owner, address and fields.
  - Fetch fields are forced to read_write=1, access_size=10, unsigned=0, data_in=0.
  - Winner's gnt=1 during T+1 only; last_owner<=winner.
  - cnt<=MEM_LATENCY-1; state<=ACCESS.
- ACCESS:
  - mem_enable=1, busy=1; mem_* driven from the latched fields (registered, no combinational path from req to mem).
  - Each cycle cnt decrements.
  - When cnt==0 at an edge, return to IDLE and pulse the owner's valid for one cycle (visible at T+1+MEM_LATENCY).
  - On that same edge, for a read, owner rdata<=mem_data_out.
  - For a store, d_rdata is unchanged.
- Requests seen outside IDLE are ignored. Requesters drop req in the cycle gnt is seen; a req still high in IDLE is treated as a new request.
- Throughput: one access per MEM_LATENCY+1 cycles; IDLE always lasts >= 1 cycle between accesses.
- rdata registers hold their value until the next valid for the same owner.
- if_valid and d_valid are never high in the same cycle; gnt and valid never overlap for the same owner.
- cnt width = clog2(MEM_LATENCY+1); no wrap, because it reloads only in IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS) and owner enum (OWNER_IF, OWNER_D).
  - Access-size constants (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10).
  - MEM_READ=1'b1, MEM_WRITE=1'b0.
- Sub-module rr_arb2: combinational two-requester round-robin pick. Inputs req[1:0] and last_owner; outputs grant_valid and winner. Reused later for register-file port sharing.

Test Plan:
- Reset check: reset low mid-run -> every output 0 immediately (async); first tie after release grants D.
- IF only, MEM_LATENCY=1, if_addr=0x100, mem_data_out=0x00500093:
  - Req in cycle 0 -> if_gnt in cycle 1.
  - mem_enable=1, mem_address=0x100, mem_read_write=1, mem_access_size=10 in cycle 1.
  - if_valid with if_rdata=0x00500093 in cycle 2.
- Simultaneous if_req and d_req held continuously, D store to 0x2000 data 0xDEADBEEF size 10:
  - Grants alternate D, IF, D, IF.
  - Store appears with mem_read_write=0, mem_data_in=0xDEADBEEF.
  - d_valid pulses with d_rdata unchanged.
- MEM_LATENCY=3, D byte load with d_unsigned=1:
  - d_gnt at T+1; busy high for 3 cycles.
  - d_valid at T+4; mem_access_size=00 and mem_unsigned=1 throughout.
  - A req toggled during ACCESS produces no extra gnt.
- Reset asserted while in ACCESS with cnt=1 -> no valid pulse afterwards; state IDLE; next req granted normally.
- Back-to-back fetches with req held: exactly one IDLE cycle between accesses; if_gnt pulses every MEM_LATENCY+1 cycles.
